// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, early coordinates, delayed sync/blank, strobes.
// Latency: x/y/display_en_early one pixel period after the counters; sync/blank a further PIPE_DELAY periods.
// Backpressure: none; free-running from clk, only reset stalls it.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_stb,
  output logic [CNT_W-1:0]   x_coord,
  output logic [CNT_W-1:0]   y_coord,
  output logic               display_en_early,
  output logic               hsync,
  output logic               vsync,
  output logic               display_en,
  output logic               vga_blank_n,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  // Sync levels: the idle level is the complement of the asserted one.
  localparam logic HS_ACT  = (H_POL != 0);
  localparam logic VS_ACT  = (V_POL != 0);
  localparam logic HS_IDLE = ~HS_ACT;
  localparam logic VS_IDLE = ~VS_ACT;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic               active;
  logic               hs_lvl, vs_lvl;
  logic [CNT_W-1:0]   x_q, y_q;
  logic               de_early_q, hs_q, vs_q;
  logic               line_start_q, frame_start_q;
  logic [FRAME_W-1:0] frame_count_q;
  logic               first_frame_q;

  // Pixel strobe is a pure decode of the divider register, so it is high every cycle when CLK_DIV is 1.
  assign pix_stb = (div_cnt_q == DIV_LAST);

  // Next-state for the divider and the raster counters; counters only move on pixel strobes.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (pix_stb) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // Region decode from the current counters, feeding the stage-1 registers.
  always_comb begin
    active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hs_lvl = ((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST)) ? HS_ACT : HS_IDLE;
    vs_lvl = ((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST)) ? VS_ACT : VS_IDLE;
  end

  // Divider and raster counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
    end
  end

  // Stage-1: coordinates and undelayed flags, loaded once per pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      de_early_q <= 1'b0;
      hs_q       <= HS_IDLE;
      vs_q       <= VS_IDLE;
    end else if (pix_stb) begin
      x_q        <= active ? hcount_q : '0;
      y_q        <= active ? vcount_q : '0;
      de_early_q <= active;
      hs_q       <= hs_lvl;
      vs_q       <= vs_lvl;
    end
  end

  // Line/frame strobes are rewritten every clk so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= pix_stb && (hcount_q == '0);
      frame_start_q <= pix_stb && (hcount_q == '0) && (vcount_q == '0);
    end
  end

  // Frame counter skips the frame_start of the first frame so it reads 0 throughout frame 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
      first_frame_q <= 1'b1;
    end else if (pix_stb && (hcount_q == '0) && (vcount_q == '0)) begin
      if (first_frame_q) begin
        first_frame_q <= 1'b0;
      end else begin
        frame_count_q <= frame_count_q + 1'b1;
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign hsync      = hs_q;
      assign vsync      = vs_q;
      assign display_en = de_early_q;
    end else begin : g_dly
      // Each entry is {hsync, vsync, active}.
      logic [2:0] dly_q [PIPE_DELAY];

      // Shift register advancing once per pixel period; reset fills it with idle levels.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            dly_q[i] <= {HS_IDLE, VS_IDLE, 1'b0};
          end
        end else if (pix_stb) begin
          dly_q[0] <= {hs_q, vs_q, de_early_q};
          for (int i = 1; i < PIPE_DELAY; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign hsync      = dly_q[PIPE_DELAY-1][2];
      assign vsync      = dly_q[PIPE_DELAY-1][1];
      assign display_en = dly_q[PIPE_DELAY-1][0];
    end
  endgenerate

  assign x_coord          = x_q;
  assign y_coord          = y_q;
  assign display_en_early = de_early_q;
  assign vga_blank_n      = display_en;
  assign line_start       = line_start_q;
  assign frame_start      = frame_start_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (defaults, small raster with 2-bit frame counter,
// inverted polarity / no delay / CLK_DIV=1) checked every cycle against an arithmetic model
// that derives every output from the number of clocks since reset was released.
module tb_vga_timing_gen;

  typedef struct {
    int d, ha, hf, hs, hb, va, vf, vs, vb, hp, vp, pd, fw;
  } cfg_t;

  typedef struct {
    logic stb, dee, hs, vs, de, ls, fs;
    int   x, y, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   t;
  int   checks = 0;
  int   failures = 0;
  cfg_t ca, cb, cc;

  always #5 clk = ~clk;

  logic       a_stb, a_dee, a_hs, a_vs, a_de, a_bn, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_stb, b_dee, b_hs, b_vs, b_de, b_bn, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [1:0] b_fc;
  logic       c_stb, c_dee, c_hs, c_vs, c_de, c_bn, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [7:0] c_fc;

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .pix_stb(a_stb), .x_coord(a_x), .y_coord(a_y),
    .display_en_early(a_dee), .hsync(a_hs), .vsync(a_vs), .display_en(a_de),
    .vga_blank_n(a_bn), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(2), .PIPE_DELAY(1), .CNT_W(4), .FRAME_W(2)
  ) u_b (
    .clk(clk), .reset(reset), .pix_stb(b_stb), .x_coord(b_x), .y_coord(b_y),
    .display_en_early(b_dee), .hsync(b_hs), .vsync(b_vs), .display_en(b_de),
    .vga_blank_n(b_bn), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .PIPE_DELAY(0)
  ) u_c (
    .clk(clk), .reset(reset), .pix_stb(c_stb), .x_coord(c_x), .y_coord(c_y),
    .display_en_early(c_dee), .hsync(c_hs), .vsync(c_vs), .display_en(c_de),
    .vga_blank_n(c_bn), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  // Expected outputs at cycle tt after reset release. m = pixel strobes already taken;
  // stage-1 shows pixel m-1, the delayed outputs show pixel m-1-pd.
  task automatic model(input cfg_t c, input int tt, output exp_t e);
    int ht, vt, m, k, h, v, kd, hd, vd;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    m  = tt / c.d;
    e.stb = ((tt + 1) % c.d) == 0;
    e.x = 0; e.y = 0; e.dee = 1'b0; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = 0;
    e.hs = (c.hp == 0); e.vs = (c.vp == 0);
    if (m >= 1) begin
      k = m - 1;
      h = k % ht;
      v = (k / ht) % vt;
      if (h < c.ha && v < c.va) begin
        e.dee = 1'b1; e.x = h; e.y = v;
      end
      if (tt % c.d == 0) begin
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
      end
      e.fc = (k / (ht * vt)) % (1 << c.fw);
      kd = k - c.pd;
      if (kd >= 0) begin
        hd = kd % ht;
        vd = (kd / ht) % vt;
        e.de = (hd < c.ha) && (vd < c.va);
        if (hd >= c.ha + c.hf && hd < c.ha + c.hf + c.hs) e.hs = (c.hp != 0);
        if (vd >= c.va + c.vf && vd < c.va + c.vf + c.vs) e.vs = (c.vp != 0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_inst(input string n, input cfg_t c, input logic stb,
                            input logic [31:0] x, input logic [31:0] y, input logic dee,
                            input logic hs, input logic vs, input logic de, input logic bn,
                            input logic ls, input logic fs, input logic [31:0] fc);
    exp_t e;
    model(c, t, e);
    chk({n, ".pix_stb"}, 32'(stb), 32'(e.stb));
    chk({n, ".x_coord"}, x, e.x);
    chk({n, ".y_coord"}, y, e.y);
    chk({n, ".display_en_early"}, 32'(dee), 32'(e.dee));
    chk({n, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({n, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({n, ".display_en"}, 32'(de), 32'(e.de));
    chk({n, ".vga_blank_n"}, 32'(bn), 32'(e.de));
    chk({n, ".line_start"}, 32'(ls), 32'(e.ls));
    chk({n, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({n, ".frame_count"}, fc, e.fc);
  endtask

  // Advance n clocks; reset changes only on the falling edge, outputs are checked there too.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      t = reset ? 0 : t + 1;
      @(negedge clk);
      check_inst("A", ca, a_stb, 32'(a_x), 32'(a_y), a_dee, a_hs, a_vs, a_de, a_bn, a_ls, a_fs, 32'(a_fc));
      check_inst("B", cb, b_stb, 32'(b_x), 32'(b_y), b_dee, b_hs, b_vs, b_de, b_bn, b_ls, b_fs, 32'(b_fc));
      check_inst("C", cc, c_stb, 32'(c_x), 32'(c_y), c_dee, c_hs, c_vs, c_de, c_bn, c_ls, c_fs, 32'(c_fc));
    end
  endtask

  initial begin
    ca = '{d:2, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:0, vp:0, pd:2, fw:8};
    cb = '{d:2, ha:8, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, hp:0, vp:0, pd:1, fw:2};
    cc = '{d:1, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:1, vp:1, pd:0, fw:8};
    t = 0;
    reset = 1'b1;
    run(3);
    // Release, then reset again when A is around hcount 300.
    reset = 1'b0;
    run(601);
    reset = 1'b1;
    run(1);
    // Long enough for B to pass five frames and wrap its 2-bit frame counter.
    reset = 1'b0;
    run(1300);
    // Randomly placed resets of random length.
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(40, 700));
      reset = 1'b1;
      run($urandom_range(1, 3));
      reset = 1'b0;
    end
    // Several full lines of A and C, many frames of B.
    run(3500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
